// File: rtl/iir_out_requant.sv
// Requantizes a 32-bit IIR filter output to 16 bits (round-half-up, saturate)
// and buffers the result in a first-word-fall-through output FIFO.
module iir_out_requant #(
    parameter int unsigned SHIFT = 15,
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] y,
    input  logic        y_valid,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sat_flag,
    output logic [15:0] sat_count,
    output logic        drop,
    output logic [6:0]  level
);

    localparam int unsigned PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = 7;
    localparam logic signed [32:0] ROUND = 33'sd1 <<< (SHIFT - 1);
    localparam logic signed [32:0] MAX_V = 33'sd32767;
    localparam logic signed [32:0] MIN_V = -33'sd32768;

    logic                pipe_vld_q, pipe_vld_d;
    logic [15:0]         pipe_data_q, pipe_data_d;
    logic                sat_flag_q, sat_flag_d;
    logic [15:0]         sat_cnt_q, sat_cnt_d;
    logic                drop_q, drop_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [15:0]         mem_q [DEPTH];

    logic signed [32:0]  sum;
    logic signed [32:0]  shifted;
    logic                clip_hi, clip_lo;
    logic [15:0]         sat_val;
    logic                pop, full, do_wr;

    // Round in 33 bits so the largest positive input cannot wrap before the shift.
    always_comb begin
        sum     = $signed({y[31], y}) + ROUND;
        shifted = sum >>> SHIFT;
        clip_hi = shifted > MAX_V;
        clip_lo = shifted < MIN_V;
        if (clip_hi) begin
            sat_val = 16'h7FFF;
        end else if (clip_lo) begin
            sat_val = 16'h8000;
        end else begin
            sat_val = shifted[15:0];
        end
    end

    always_comb begin
        pipe_vld_d  = y_valid;
        pipe_data_d = pipe_data_q;
        sat_flag_d  = 1'b0;
        sat_cnt_d   = sat_cnt_q;
        if (y_valid) begin
            pipe_data_d = sat_val;
            sat_flag_d  = clip_hi | clip_lo;
            if ((clip_hi | clip_lo) && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_d = sat_cnt_q + 16'd1;
            end
        end
    end

    // A write into a full FIFO is still accepted when the head pops on the same edge.
    always_comb begin
        pop      = (level_q != '0) && out_ready;
        full     = (level_q == LVL_W'(DEPTH));
        do_wr    = pipe_vld_q && (!full || pop);
        drop_d   = drop_q | (pipe_vld_q && full && !pop);
        wr_ptr_d = do_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({do_wr, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q  <= 1'b0;
            pipe_data_q <= '0;
            sat_flag_q  <= 1'b0;
            sat_cnt_q   <= '0;
            drop_q      <= 1'b0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
            sat_flag_q  <= sat_flag_d;
            sat_cnt_q   <= sat_cnt_d;
            drop_q      <= drop_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= pipe_data_q;
        end
    end

    // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_cnt_q;
    assign drop      = drop_q;
    assign level     = level_q;

endmodule

// File: tb/tb_iir_out_requant.sv
// Directed, table-driven bench for iir_out_requant (SHIFT=15, DEPTH=8).
module tb_iir_out_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] y;
    logic        y_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat_flag;
    logic [15:0] sat_count;
    logic        drop;
    logic [6:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    iir_out_requant #(.SHIFT(15), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .y         (y),
        .y_valid   (y_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .sat_count (sat_count),
        .drop      (drop),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic [15:0] data;
        logic        sat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        y_valid = 1'b0;
        out_ready = 1'b0;
        y = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int exp_sat_cnt;

        vecs[0]  = '{32'h0000_8000, 16'h0001, 1'b0};
        vecs[1]  = '{32'hFFFF_C000, 16'h0000, 1'b0};
        vecs[2]  = '{32'hFFFF_BFFF, 16'hFFFF, 1'b0};
        vecs[3]  = '{32'h3FFF_8000, 16'h7FFF, 1'b0};
        vecs[4]  = '{32'h4000_0000, 16'h7FFF, 1'b1};
        vecs[5]  = '{32'h8000_0000, 16'h8000, 1'b1};
        vecs[6]  = '{32'h7FFF_FFFF, 16'h7FFF, 1'b1};
        vecs[7]  = '{32'h0000_4000, 16'h0001, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFF, 16'h0000, 1'b0};
        vecs[9]  = '{32'hC000_0000, 16'h8000, 1'b0};
        vecs[10] = '{32'hBFFF_BFFF, 16'h8000, 1'b1};

        // Reset state
        rst = 1'b1;
        y_valid = 1'b0;
        out_ready = 1'b0;
        y = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_sat_count", 32'(sat_count), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Rounding, saturation and two-edge latency, one sample at a time
        out_ready = 1'b1;
        exp_sat_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            y = vecs[i].y;
            y_valid = 1'b1;
            step();
            y_valid = 1'b0;
            if (vecs[i].sat) exp_sat_cnt++;
            check($sformatf("v%0d_sat_flag", i), 32'(sat_flag), 32'(vecs[i].sat));
            check($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
            step();
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].data));
            step();
            check($sformatf("v%0d_level_after_pop", i), 32'(level), 32'd0);
        end
        check("sat_count", 32'(sat_count), 32'(exp_sat_cnt));

        // Full FIFO drops the overflow samples and keeps the oldest eight
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            y = 32'(i) << 15;
            y_valid = 1'b1;
            step();
        end
        y_valid = 1'b0;
        step();
        step();
        check("full_level", 32'(level), 32'd8);
        check("full_drop", 32'(drop), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("drain_data_%0d", i), 32'(out_data), 32'(i));
            step();
        end
        check("drain_empty", 32'(level), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Write and pop on the same edge while full
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            y = 32'(i) << 15;
            y_valid = 1'b1;
            step();
        end
        y_valid = 1'b0;
        check("simul_pre_level", 32'(level), 32'd8);
        check("simul_pre_head", 32'(out_data), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("simul_level", 32'(level), 32'd8);
        check("simul_drop", 32'(drop), 32'd0);
        check("simul_head", 32'(out_data), 32'd2);
        step();
        check("simul_hold", 32'(out_data), 32'd2);
        out_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            check($sformatf("simul_drain_%0d", i), 32'(out_data), 32'(i));
            step();
        end
        check("simul_drain_empty", 32'(level), 32'd0);
        out_ready = 1'b0;

        // Reset mid-stream with a sample in the pipeline register
        do_reset();
        y = 32'h4000_0000;
        y_valid = 1'b1;
        step();
        for (int i = 2; i <= 6; i++) begin
            y = 32'(i) << 15;
            step();
        end
        check("mid_level", 32'(level), 32'd5);
        check("mid_sat_count", 32'(sat_count), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_sat_count", 32'(sat_count), 32'd0);
        check("mid_rst_drop", 32'(drop), 32'd0);
        check("mid_rst_sat_flag", 32'(sat_flag), 32'd0);
        y = 32'h0000_8000;
        step();
        rst = 1'b0;
        y_valid = 1'b0;
        step();
        check("post_rst_ignored", 32'(level), 32'd0);
        check("post_rst_ignored_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        y = 32'h0003_8000;
        y_valid = 1'b1;
        step();
        y_valid = 1'b0;
        check("post_rst_early", 32'(out_valid), 32'd0);
        step();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'd7);
        check("post_rst_level", 32'(level), 32'd1);
        step();
        check("post_rst_alone", 32'(level), 32'd0);
        check("post_rst_alone_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_out_requant.md
IIR_OUT_REQUANT -- requirements
Module: iir_out_requant

Interface
REQ-001 SHALL have parameter SHIFT, default 15: right-shift applied to the 32-bit filter output, legal range 1..16.
REQ-002 SHALL have parameter DEPTH, default 8: output FIFO depth in samples, power of two, legal range 2..64.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port y  input  32  signed filter output sample, two's complement.
REQ-006 SHALL have port y_valid  input  1  y is a new sample this cycle.
REQ-007 SHALL have port out_data  output  16  signed requantized sample at the FIFO head.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid sample.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 SHALL have port sat_flag  output  1  the sample in the pipeline register was clipped.
REQ-011 SHALL have port sat_count  output  16  count of clipped samples, sticky at 0xFFFF.
REQ-012 SHALL have port drop  output  1  sticky flag: at least one sample was lost to a full FIFO.
REQ-013 SHALL have port level  output  7  current FIFO occupancy, 0..DEPTH.

Function
REQ-014 SHALL compute r = (y + 2^(SHIFT-1)) >>> SHIFT using 33-bit signed arithmetic, so y = 0x7FFFFFFF causes no wrap.
REQ-015 SHALL saturate r to [-32768, 32767]; a clipped value asserts sat_flag for that sample.
REQ-016 SHALL register the result and its valid bit in a single pipeline stage on each edge where y_valid = 1; when y_valid = 0, the stage valid bit SHALL clear.
REQ-017 SHALL increment sat_count on the edge that loads a clipped sample; sat_count SHALL hold at 0xFFFF.
REQ-018 SHALL write the pipeline register into the FIFO on the next edge while its valid bit is 1.
REQ-019 SHALL implement the FIFO as first-word-fall-through: out_valid = (level != 0); out_data = head entry.
REQ-020 SHALL pop the head on an edge where out_valid = 1 and out_ready = 1; out_ready while empty SHALL have no effect.
REQ-021 SHALL, when a write and a pop occur on the same edge, perform both and leave level unchanged, including when level = DEPTH.
REQ-022 SHALL, when a write occurs at level = DEPTH without a pop, discard the new sample, keep the FIFO contents, and set drop.
REQ-023 SHALL wrap read and write pointers modulo DEPTH; level SHALL never exceed DEPTH or underflow below 0.
REQ-024 SHALL have a latency of 2 edges: a sample presented at edge k with an empty FIFO appears on out_data with out_valid = 1 after edge k+1.
REQ-025 SHALL preserve sample order; no sample SHALL be duplicated.
REQ-026 SHALL hold out_data stable while out_valid = 1 and out_ready = 0.

Reset
REQ-027 SHALL, while rst = 1, force the following asynchronously: out_valid = 0, out_data = 0, sat_flag = 0, sat_count = 0, drop = 0, level = 0, pipeline valid bit = 0, and both pointers = 0.
REQ-028 SHALL discard all in-flight and buffered samples when rst asserts mid-stream; the first sample after release SHALL follow REQ-024 timing.
REQ-029 SHALL ignore y_valid on any edge where rst = 1.

Verification
REQ-030 SHALL cover rounding at SHIFT=15, out_ready=1: y = 0x00008000 -> 0x0001; y = 0xFFFFC000 -> 0x0000; y = 0xFFFFBFFF -> 0xFFFF; y = 0x3FFF8000 -> 0x7FFF with sat_flag=0.
REQ-031 SHALL cover saturation: y = 0x40000000 -> 0x7FFF with sat_flag=1; y = 0x80000000 -> 0x8000 with sat_flag=1; y = 0x7FFFFFFF -> 0x7FFF; after these three samples, sat_count = 3.
REQ-032 SHALL cover latency: a single y_valid pulse at edge k into an empty FIFO -> out_valid rises after edge k+1; out_ready=1 -> level returns to 0 after edge k+2.
REQ-033 SHALL cover full and drop: out_ready=0 with 10 consecutive samples 1..10 (DEPTH=8) -> level = 8, drop = 1; the drained output is exactly samples 1..8 in order.
REQ-034 SHALL cover simultaneous events: at level = 8, a write and a pop on the same edge -> level stays 8, drop stays 0, head advances by one sample.
REQ-035 SHALL cover reset mid-stream: rst asserted at level = 5 with a sample in the pipeline register -> all outputs go to 0 immediately; after release, the next sample emerges alone after 2 edges.
